// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: per-channel state
// encoding, counter widths and the parameter legality check used at
// elaboration time by the top level.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat while held).
package btn_pkg;

  // Debounce qualification counter width.
  localparam int CNT_W  = 8;
  // Auto-repeat hold counter width.
  localparam int HOLD_W = 16;

  // Per-channel FSM state. REPEAT is reachable only with BTN_REPEAT_EN.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Legal parameter ranges. The repeat delay plus one repeat period must
  // fit in the hold counter so the repeat cadence never hits saturation.
  function automatic bit params_ok(input int channels,
                                   input int tick_div,
                                   input int stable_n,
                                   input int repeat_delay,
                                   input int repeat_rate);
    return (channels >= 1) && (channels <= 32) &&
           (tick_div >= 2) &&
           (stable_n >= 1) && (stable_n <= 255) &&
           (repeat_delay >= 1) && (repeat_rate >= 1) &&
           ((repeat_delay + repeat_rate) <= (2 ** HOLD_W) - 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-qualified debounce counter,
// IDLE/ACTIVE(/REPEAT) FSM and registered single-cycle press/release strobes.
// Optional feature macro: BTN_REPEAT_EN adds the hold counter and REPEAT.
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_N = 5
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_state_e       state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             level;
  logic             differs;
  logic             accept;

`ifdef BTN_REPEAT_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic [HOLD_W-1:0] REP_FIRST = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] REP_NEXT  = HOLD_W'(REPEAT_DELAY + REPEAT_RATE);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
`endif

  assign level   = (state_q != IDLE);
  assign differs = (sync2_q != level);
  assign accept  = tick_i && differs && (cnt_q == CNT_LAST);

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values and the sync chain really is two stages.
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, FSM and strobe next-state logic; everything holds between ticks.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_REPEAT_EN
    hold_d    = hold_q;
    hold_inc  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
`endif
    if (tick_i) begin
      if (accept) begin
        cnt_d = '0;
        if (level) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          state_d = ACTIVE;
          press_d = 1'b1;
        end
      end else if (differs) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
`ifdef BTN_REPEAT_EN
      if (accept && !level) begin
        hold_d = '0;
      end else if (level && !accept) begin
        hold_d = hold_inc;
        if (state_q == ACTIVE && hold_inc == REP_FIRST) begin
          press_d = 1'b1;
          state_d = REPEAT;
        end else if (state_q == REPEAT && hold_inc == REP_NEXT) begin
          // Fold back to the delay point so the cadence repeats forever.
          press_d = 1'b1;
          hold_d  = REP_FIRST;
        end
      end
`endif
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_REPEAT_EN
  // Hold counter for auto-repeat timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign level_o   = level;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: shared sample-tick generator plus
// one btn_channel per button, producing clean levels and 1-cycle strobes.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat PRESS while held).
module button_conditioner
  import btn_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_N     = 5,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic                tick_o
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (!params_ok(CHANNELS, TICK_DIV, STABLE_N, REPEAT_DELAY, REPEAT_RATE))
  begin : g_param_err
    $error("button_conditioner: parameter out of range");
  end

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // Free-running divider that wraps after TICK_DIV cycles.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
  end

  // Tick divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_o = (tick_cnt_q == TICK_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    btn_channel #(
      .STABLE_N     (STABLE_N)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick_o),
      .button_i  (button_i[g]),
      .level_o   (level_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: behavioural model compared
// every cycle, directed scenarios with hand-computed timings, random stimulus.
module tb_button_conditioner;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int SN = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] button_i = '0;
  logic [CH-1:0] level_o;
  logic [CH-1:0] press_o;
  logic [CH-1:0] release_o;
  logic          tick_o;

  int vectors = 0;
  int miscompares = 0;

  button_conditioner #(
    .CHANNELS     (CH),
    .TICK_DIV     (TD),
    .STABLE_N     (SN),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button_i  (button_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .tick_o    (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges since reset release decide where ticks fall; a pin value reaches
  // the debouncer two edges after it is sampled; a level changes after SN
  // consecutive differing samples.
  int edges;
  bit hist0 [CH];
  bit hist1 [CH];
  bit m_level [CH];
  int m_run [CH];
  int m_held [CH];
  bit m_press [CH];
  bit m_rel [CH];
  bit m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges  = 0;
      m_tick = 1'b0;
      for (int c = 0; c < CH; c++) begin
        hist0[c] = 1'b0; hist1[c] = 1'b0; m_level[c] = 1'b0;
        m_run[c] = 0; m_held[c] = 0; m_press[c] = 1'b0; m_rel[c] = 1'b0;
      end
    end else begin
      bit tick_now;
      tick_now = (edges % TD) == TD - 1;
      edges++;
      for (int c = 0; c < CH; c++) begin
        bit old_level;
        old_level  = m_level[c];
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        if (tick_now) begin
          if (hist1[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == SN) begin
              m_run[c]   = 0;
              m_level[c] = !m_level[c];
              if (m_level[c]) begin
                m_press[c] = 1'b1;
                m_held[c]  = 0;
              end else begin
                m_rel[c] = 1'b1;
              end
            end
          end else begin
            m_run[c] = 0;
          end
`ifdef BTN_REPEAT_EN
          if (old_level && !m_rel[c]) begin
            m_held[c]++;
            if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RR == 0))
              m_press[c] = 1'b1;
          end
`endif
        end
        hist1[c] = hist0[c];
        hist0[c] = button_i[c];
      end
      m_tick = (edges % TD) == TD - 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [CH-1:0] e_level, e_press, e_rel;

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < CH; c++) begin
      e_level[c] = m_level[c];
      e_press[c] = m_press[c];
      e_rel[c]   = m_rel[c];
    end
    check("tick", 32'(tick_o), 32'(m_tick));
    check("level", 32'(level_o), 32'(e_level));
    check("press", 32'(press_o), 32'(e_press));
    check("release", 32'(release_o), 32'(e_rel));
    check("press_and_release", 32'(press_o & release_o), 32'd0);
  end

  // ---------------- directed helpers ----------------
  // Returns just after an edge that leaves TICK high, so the next negedge
  // sits right before a sampling edge.
  task automatic align_tick();
    for (int i = 0; i < 2 * TD; i++) begin
      @(posedge clk); #1;
      if (tick_o) return;
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Watches one channel for n edges; reports the first strobe edges and counts.
  task automatic watch(input int ch, input int n,
                       output int first_p, output int n_p,
                       output int first_r, output int n_r);
    first_p = 0; n_p = 0; first_r = 0; n_r = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (press_o[ch]) begin
        if (n_p == 0) first_p = i;
        n_p++;
      end
      if (release_o[ch]) begin
        if (n_r == 0) first_r = i;
        n_r++;
      end
    end
  endtask

  initial begin
    int fp, np, fr, nr;
    int t1, t2;
    logic [1:0] pair;

    // 1. reset with all pins high, outputs quiet
    button_i = 4'hF;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level", 32'(level_o), 32'd0);
    check("reset_strobes", 32'(press_o | release_o), 32'd0);
    check("reset_tick", 32'(tick_o), 32'd0);
    button_i = '0;
    rst_n    = 1'b1;
    t1 = 0; t2 = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (tick_o) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    check("first_tick_edge", 32'(t1), 32'd3);
    check("tick_period", 32'(t2 - t1), 32'(TD));

    // 2. clean press on channel 0: samples at +5,+9,+13 edges
    align_tick();
    @(negedge clk); button_i[0] = 1'b1;
    watch(0, 16, fp, np, fr, nr);
    check("press0_edge", 32'(fp), 32'd13);
    check("press0_count", 32'(np), 32'd1);
    check("level0_high", 32'(level_o[0]), 32'd1);

    // 3. bounce 1,0,1 on channel 1 then hold: accept at edge 21
    align_tick();
    fp = 0; np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) button_i[1] = 1'b1;
      if (i == 4) button_i[1] = 1'b0;
      if (i == 8) button_i[1] = 1'b1;
      @(posedge clk); #1;
      if (press_o[1]) begin
        if (np == 0) fp = i + 1;
        np++;
      end
    end
    check("bounce_press_edge", 32'(fp), 32'd21);
    check("bounce_press_count", 32'(np), 32'd1);

    // 4. release channel 0
    align_tick();
    @(negedge clk); button_i[0] = 1'b0;
    watch(0, 16, fp, np, fr, nr);
    check("release0_edge", 32'(fr), 32'd13);
    check("release0_count", 32'(nr), 32'd1);
`ifndef BTN_REPEAT_EN
    check("release0_no_press", 32'(np), 32'd0);
`endif
    check("level0_low", 32'(level_o[0]), 32'd0);

    // 5. channels 2 and 3 together
    align_tick();
    @(negedge clk); button_i[3:2] = 2'b11;
    pair = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 13) pair = press_o[3:2];
    end
    check("dual_press", 32'(pair), 32'd3);

`ifdef BTN_REPEAT_EN
    // 6. auto-repeat on channel 0: 13, then +5 ticks (33), then every 2 ticks
    begin
      int pe [$];
      align_tick();
      @(negedge clk); button_i[0] = 1'b1;
      for (int i = 1; i <= 50; i++) begin
        @(posedge clk); #1;
        if (press_o[0]) pe.push_back(i);
      end
      check("repeat_count", 32'(pe.size()), 32'd4);
      if (pe.size() == 4) begin
        check("repeat_accept", 32'(pe[0]), 32'd13);
        check("repeat_first", 32'(pe[1]), 32'd33);
        check("repeat_second", 32'(pe[2]), 32'd41);
        check("repeat_third", 32'(pe[3]), 32'd49);
      end
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("midrepeat_reset_level", 32'(level_o), 32'd0);
      check("midrepeat_reset_strobes", 32'(press_o | release_o | CH'(tick_o)), 32'd0);
      @(negedge clk); rst_n = 1'b1;
    end
`endif

    // Random phase: toggling pins with varied dwell, one reset in flight.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) button_i[c] = ~button_i[c];
      if (i == 700) rst_n = 1'b0;
      if (i == 703) rst_n = 1'b1;
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
